// File: rtl/prach_fft3_frame_seq_if.sv
// -----------------------------------------------------------------------------
// prach_fft3_frame_seq_if
//   Sample-stream bundle around the PRACH radix-3 frame sequencer.
//   s_*  : raw framed sample stream entering the sequencer.
//   bf_* : admitted, indexed sample stream leaving towards the butterfly.
//   Modports:
//     master : upstream side; drives s_*, observes bf_*.
//     slave  : the sequencer; consumes s_*, drives bf_*.
// -----------------------------------------------------------------------------
interface prach_fft3_frame_seq_if #(
   parameter int IDXW = 11
);
   logic signed [17:0] s_dr;
   logic signed [17:0] s_di;
   logic               s_dv;
   logic               s_sop;
   logic signed [17:0] bf_dr;
   logic signed [17:0] bf_di;
   logic               bf_dv;
   logic               bf_sync;
   logic [1:0]         bf_phase;
   logic [IDXW-1:0]    bf_idx;

   modport master (
      output s_dr, s_di, s_dv, s_sop,
      input  bf_dr, bf_di, bf_dv, bf_sync, bf_phase, bf_idx
   );

   modport slave (
      input  s_dr, s_di, s_dv, s_sop,
      output bf_dr, bf_di, bf_dv, bf_sync, bf_phase, bf_idx
   );
endinterface

// File: rtl/prach_fft3_frame_seq.sv
// -----------------------------------------------------------------------------
// prach_fft3_frame_seq
//   Frame sequencer in front of the radix-3 DIT butterfly of the PRACH
//   long-format FFT. Admits only complete frames of N_FFT samples that start
//   with s_sop, tags each forwarded sample with index, triplet phase and a
//   sync pulse on sample 0, and reports completion, short frames and stalls.
//
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     en           frame admission enable (sop in IDLE, restart on short frame)
//     sif          slave side of the sample stream bundle (s_* in, bf_* out)
//     frame_done   pulse with sample N_FFT-1
//     err_short    pulse when s_sop arrives before the frame completed
//     err_timeout  pulse when a frame is aborted after TIMEOUT idle cycles
//     busy         high while in RUN
//     cnt_ok       completed frames, saturating
//     cnt_err      aborted frames, saturating
//
//   Every output is a register: one cycle from s_* to bf_*/status.
//   Constraints: N_FFT multiple of 3 and >= 3, 2^IDXW >= N_FFT, TIMEOUT >= 1.
// -----------------------------------------------------------------------------
module prach_fft3_frame_seq #(
   parameter int N_FFT   = 1536,
   parameter int IDXW    = 11,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   prach_fft3_frame_seq_if.slave sif,
   output logic                 frame_done,
   output logic                 err_short,
   output logic                 err_timeout,
   output logic                 busy,
   output logic [CNTW-1:0]      cnt_ok,
   output logic [CNTW-1:0]      cnt_err
);

   // Gap counter only has to reach TIMEOUT-1; the abort fires on that cycle.
   localparam int GAPW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_FFT - 1);
   localparam logic [GAPW-1:0] GAP_LAST = GAPW'(TIMEOUT - 1);
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDXW-1:0]    idx_q, idx_d;       // index the next in-frame sample gets
   logic [1:0]         phase_q, phase_d;   // triplet phase of the next sample
   logic [GAPW-1:0]    gap_q, gap_d;       // consecutive no-valid cycles in RUN

   logic signed [17:0] bf_dr_q, bf_dr_d;
   logic signed [17:0] bf_di_q, bf_di_d;
   logic               bf_dv_q, bf_dv_d;
   logic               bf_sync_q, bf_sync_d;
   logic [1:0]         bf_phase_q, bf_phase_d;
   logic [IDXW-1:0]    bf_idx_q, bf_idx_d;
   logic               frame_done_q, frame_done_d;
   logic               err_short_q, err_short_d;
   logic               err_timeout_q, err_timeout_d;
   logic               busy_q, busy_d;
   logic [CNTW-1:0]    cnt_ok_q, cnt_ok_d;
   logic [CNTW-1:0]    cnt_err_q, cnt_err_d;

   logic               fwd_s;
   logic               sync_s;
   logic [IDXW-1:0]    fidx_s;
   logic [1:0]         fphase_s;
   logic               done_s;
   logic               short_s;
   logic               tmo_s;

   // Frame state machine: decides admission, indexing, abort and completion.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      phase_d  = phase_q;
      gap_d    = gap_q;
      fwd_s    = 1'b0;
      sync_s   = 1'b0;
      fidx_s   = {IDXW{1'b0}};
      fphase_s = 2'd0;
      done_s   = 1'b0;
      short_s  = 1'b0;
      tmo_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sif.s_dv && sif.s_sop && en) begin
               fwd_s   = 1'b1;
               sync_s  = 1'b1;
               state_d = ST_RUN;
               idx_d   = IDXW'(1);
               phase_d = 2'd1;
               gap_d   = {GAPW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (sif.s_dv) begin
               // Any valid sample (even a short-frame sop) ends the stall.
               gap_d = {GAPW{1'b0}};
               if (sif.s_sop) begin
                  // Any sop in RUN is premature: the frame never completed.
                  short_s = 1'b1;
                  if (en) begin
                     fwd_s   = 1'b1;
                     sync_s  = 1'b1;
                     idx_d   = IDXW'(1);
                     phase_d = 2'd1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  fwd_s    = 1'b1;
                  fidx_s   = idx_q;
                  fphase_s = phase_q;
                  if (idx_q == IDX_LAST) begin
                     // Going IDLE now lets a sop on the next cycle start a frame.
                     done_s  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     idx_d   = idx_q + IDXW'(1);
                     phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                  end
               end
            end else begin
               if (gap_q == GAP_LAST) begin
                  tmo_s   = 1'b1;
                  state_d = ST_IDLE;
                  gap_d   = {GAPW{1'b0}};
               end else begin
                  gap_d = gap_q + GAPW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and saturating status counters.
   always_comb begin
      bf_dv_d       = fwd_s;
      bf_sync_d     = sync_s;
      frame_done_d  = done_s;
      err_short_d   = short_s;
      err_timeout_d = tmo_s;
      busy_d        = (state_d == ST_RUN);
      if (fwd_s) begin
         bf_dr_d    = sif.s_dr;
         bf_di_d    = sif.s_di;
         bf_phase_d = fphase_s;
         bf_idx_d   = fidx_s;
      end else begin
         bf_dr_d    = 18'sd0;
         bf_di_d    = 18'sd0;
         bf_phase_d = 2'd0;
         bf_idx_d   = {IDXW{1'b0}};
      end
      if (done_s && (cnt_ok_q != CNT_MAX)) begin
         cnt_ok_d = cnt_ok_q + CNTW'(1);
      end else begin
         cnt_ok_d = cnt_ok_q;
      end
      if ((short_s || tmo_s) && (cnt_err_q != CNT_MAX)) begin
         cnt_err_d = cnt_err_q + CNTW'(1);
      end else begin
         cnt_err_d = cnt_err_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= {IDXW{1'b0}};
         phase_q       <= 2'd0;
         gap_q         <= {GAPW{1'b0}};
         bf_dr_q       <= 18'sd0;
         bf_di_q       <= 18'sd0;
         bf_dv_q       <= 1'b0;
         bf_sync_q     <= 1'b0;
         bf_phase_q    <= 2'd0;
         bf_idx_q      <= {IDXW{1'b0}};
         frame_done_q  <= 1'b0;
         err_short_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         cnt_ok_q      <= {CNTW{1'b0}};
         cnt_err_q     <= {CNTW{1'b0}};
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         phase_q       <= phase_d;
         gap_q         <= gap_d;
         bf_dr_q       <= bf_dr_d;
         bf_di_q       <= bf_di_d;
         bf_dv_q       <= bf_dv_d;
         bf_sync_q     <= bf_sync_d;
         bf_phase_q    <= bf_phase_d;
         bf_idx_q      <= bf_idx_d;
         frame_done_q  <= frame_done_d;
         err_short_q   <= err_short_d;
         err_timeout_q <= err_timeout_d;
         busy_q        <= busy_d;
         cnt_ok_q      <= cnt_ok_d;
         cnt_err_q     <= cnt_err_d;
      end
   end

   assign sif.bf_dr    = bf_dr_q;
   assign sif.bf_di    = bf_di_q;
   assign sif.bf_dv    = bf_dv_q;
   assign sif.bf_sync  = bf_sync_q;
   assign sif.bf_phase = bf_phase_q;
   assign sif.bf_idx   = bf_idx_q;
   assign frame_done   = frame_done_q;
   assign err_short    = err_short_q;
   assign err_timeout  = err_timeout_q;
   assign busy         = busy_q;
   assign cnt_ok       = cnt_ok_q;
   assign cnt_err      = cnt_err_q;

endmodule

// File: doc/prach_fft3_frame_seq.md
Name: prach_fft3_frame_seq

Overview:
- Frame sequencer in front of the radix-3 DIT butterfly stage of the PRACH long-format FFT.
- Accepts the raw sample stream with start-of-packet framing and admits only complete, well-formed frames of N_FFT samples.
- Drives the butterfly's data/valid/sync inputs, with sync aligned to sample 0 and triplet phase tracked.
- Reports frame completion and framing errors: short frame or input stall.

Parameters:
- N_FFT, 1536: samples per FFT frame; must be a multiple of 3 and at least 3.
- IDXW, 11: width of the sample index; must satisfy 2^IDXW >= N_FFT.
- TIMEOUT, 64: number of consecutive no-valid cycles inside a frame that aborts the frame; must be at least 1.
- CNTW, 16: width of the status counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  frame-admission enable.
- s_dr  in  18  input sample, real part, signed.
- s_di  in  18  input sample, imaginary part, signed.
- s_dv  in  1  input sample valid.
- s_sop  in  1  start of frame; qualified by s_dv.
- bf_dr  out  18  sample to butterfly, real part.
- bf_di  out  18  sample to butterfly, imaginary part.
- bf_dv  out  1  sample valid to butterfly.
- bf_sync  out  1  one-cycle pulse with sample 0 of each admitted frame.
- bf_phase  out  2  triplet phase (0, 1, 2) of the current bf sample.
- bf_idx  out  IDXW  sample index within the frame.
- frame_done  out  1  pulse with sample N_FFT-1.
- err_short  out  1  pulse: new s_sop arrived before the current frame completed.
- err_timeout  out  1  pulse: frame aborted on stall.
- busy  out  1  high while in RUN.
- cnt_ok  out  CNTW  number of completed frames; saturating.
- cnt_err  out  CNTW  number of aborted frames; saturating.

Behaviour:
- Reset and registering:
  - All outputs are registered.
  - Reset clears every output to 0, sets the state to IDLE, and clears the index, phase and gap counters.
- Latency: 1 cycle from the s_* inputs to bf_*, frame_done, err_* and busy.
- bf_dr and bf_di equal the input sample when bf_dv=1; otherwise they are 0.
- s_sop with s_dv=0 is ignored in every state.
- State IDLE:
  - s_dv & s_sop & en: forward the sample with bf_sync=1, bf_idx=0, bf_phase=0; go to RUN.
  - Any other s_dv: sample is dropped, bf_dv=0.
- State RUN, s_dv=1 and s_sop=0:
  - Forward the sample; idx increments by 1.
  - phase increments with wrap 2 -> 0.
  - The gap counter clears.
- State RUN, last sample (forwarded idx = N_FFT-1):
  - frame_done=1 and cnt_ok increments on the same output cycle.
  - Go to IDLE.
  - A s_sop on the very next input cycle is accepted, so back-to-back frames run with no bubble.
- State RUN, s_dv & s_sop before the frame completes (idx < N_FFT-1 pending):
  - err_short=1 and cnt_err increments.
  - If en=1: the sample restarts the frame with bf_sync=1, idx=0, phase=0; remain in RUN.
  - If en=0: the sample is dropped; go to IDLE.
- State RUN, s_dv=0:
  - The gap counter increments.
  - On the TIMEOUT-th consecutive no-valid cycle: err_timeout=1 on the following cycle, cnt_err increments, go to IDLE.
  - No bf_dv is emitted by the abort.
- en deasserted in RUN: the current frame continues to completion. en gates only admission, meaning sop acceptance in IDLE and restart on a short frame.
- Simultaneous events:
  - If s_dv=1 arrives on the cycle the gap counter would expire, the sample wins; there is no timeout.
  - err_short and frame_done are never asserted together.
- Counters: cnt_ok and cnt_err saturate at all-ones and never wrap.
- busy is 1 exactly while the state is RUN, delayed by the 1-cycle output register.
- Reset mid-frame: immediate return to IDLE with all outputs 0; the partial frame is not counted as an error.

Test Plan:
- Basic frame:
  - Stimulus: reset, en=1, s_sop on sample 0, then 1536 contiguous samples with dr=k, di=-k.
  - Required: bf_sync pulses once, 1 cycle after input sample 0; bf_phase cycles 0,1,2; bf_idx=1535 together with frame_done; cnt_ok=1, cnt_err=0; busy falls after the last sample.
- No start of frame:
  - Stimulus: 10 valid samples without s_sop while in IDLE.
  - Required: bf_dv stays 0 throughout; busy=0.
- Short frame:
  - Stimulus: s_sop again at input sample 100.
  - Required: err_short pulse; bf_sync with bf_idx=0 on that sample; cnt_err=1.
  - Then complete 1536 samples. Required: frame_done, cnt_ok=1.
- Repeat short frame with en=0: the sample is dropped and the block returns to IDLE.
- Stall:
  - Stimulus: mid-frame gap of 63 cycles, then resume.
  - Required: no error; the frame completes normally.
  - Stimulus: gap of 64 cycles.
  - Required: err_timeout 1 cycle after the 64th idle cycle; busy=0; cnt_err increments; later samples without sop are dropped.
- en drop: deassert en at idx 500.
  - Required: frame completes with frame_done.
  - A following s_sop is ignored and bf_dv stays 0.
- Back-to-back frames and saturation, with N_FFT=6, CNTW=2:
  - Stimulus: 5 back-to-back frames with sop on the cycle after each last sample.
  - Required: continuous bf_dv with a bf_sync every 6 cycles; frame_done 5 times; cnt_ok saturates at 3.
